// File: rtl/gf_poly_mult_seq.sv
// Sequential carry-less (GF(2)) polynomial multiplier, one multiplier bit per clock.
// Optional macro GF_SKIP_ZERO_EN ends RUN early once no set multiplier bits remain.
`timescale 1ns/1ps
module gf_poly_mult_seq #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] p
);

   localparam int CW = $clog2(W) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [2*W-1:0]   a_sh_q, a_sh_d;
   logic [W-1:0]     b_sh_q, b_sh_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [2*W-1:0]   p_q, p_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2*W-1:0]   term;
   logic             last_step;

   // NOTE: reset is sampled on the clock edge, and every register (including the
   // datapath) is cleared so an aborted operation leaves p at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         acc_q   <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         acc_q   <= acc_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      // NOTE: hold-value defaults first, so no path through the case infers a latch.
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      acc_d   = acc_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      term    = b_sh_q[0] ? a_sh_q : '0;
`ifdef GF_SKIP_ZERO_EN
      last_step = (cnt_q == CW'(W - 1)) || ((b_sh_q >> 1) == '0);
`else
      last_step = (cnt_q == CW'(W - 1));
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = {{W{1'b0}}, a};
               b_sh_d  = b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d  = acc_q ^ term;
            a_sh_d = a_sh_q << 1;
            b_sh_d = b_sh_q >> 1;
            cnt_d  = cnt_q + CW'(1);
            if (last_step) begin
               // The final partial product is folded in directly rather than via acc_q.
               p_d     = acc_q ^ term;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
      p    = p_q;
   end

endmodule

// File: tb/tb_gf_poly_mult_seq.sv
// Self-checking bench for gf_poly_mult_seq against a loop-based GF(2) product model.
// Latency expectations follow GF_SKIP_ZERO_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_gf_poly_mult_seq;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst_n, start;
   logic [W-1:0]   a, b;
   logic           busy, done;
   logic [2*W-1:0] p;

   int             errors = 0;
   int             checks = 0;
   logic [2*W-1:0] exp_p  = '0;

   always #5 clk = ~clk;

   gf_poly_mult_seq #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .p(p)
   );

   function automatic logic [2*W-1:0] clmul(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [2*W-1:0] r = '0;
      for (int i = 0; i < W; i++)
         for (int j = 0; j < W; j++)
            if (x[i] && y[j]) r[i+j] = ~r[i+j];
      return r;
   endfunction

   function automatic int run_steps(input logic [W-1:0] y);
`ifdef GF_SKIP_ZERO_EN
      int n = 1;
      for (int i = 0; i < W; i++) if (y[i]) n = i + 1;
      return n;
`else
      return W;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation; poke re-asserts start and scrambles a during RUN.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input bit poke,
                        input string name);
      int n, got;
      n = run_steps(tbv);
      got = -1;
      a = ta; b = tbv; start = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b1 || p !== exp_p) begin
         errors++;
         $display("FAIL %s accept: busy=%b p=%h, want busy=1 p=%h", name, busy, p, exp_p);
      end
      start = poke;
      if (poke) a = '1;
      for (int k = 1; k <= 3 * W; k++) begin
         tick();
         if (poke && k == 1) start = 1'b0;
         if (done === 1'b1) begin
            got = k;
            break;
         end
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy in RUN edge %0d: got %b want 1", name, k, busy);
         end
      end
      exp_p = clmul(ta, tbv);
      checks++;
      if (got != n) begin
         errors++;
         $display("FAIL %s latency: done after edge %0d, want %0d", name, got, n);
      end
      checks++;
      if (p !== exp_p || busy !== 1'b1 || p[2*W-1] !== 1'b0) begin
         errors++;
         $display("FAIL %s product: p=%h busy=%b, want p=%h busy=1", name, p, busy, exp_p);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || p !== exp_p) begin
         errors++;
         $display("FAIL %s return idle: done=%b busy=%b p=%h, want 0 0 %h",
                  name, done, busy, p, exp_p);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s stays idle: done=%b busy=%b, want 0 0", name, done, busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; a = 4'b1011; b = 4'b0111;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if (busy !== 1'b0 || done !== 1'b0 || p !== 8'h00) begin
            errors++;
            $display("FAIL reset edge %0d: busy=%b done=%b p=%h, want 0 0 00", k, busy, done, p);
         end
      end
      start = 1'b0; rst_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset no start: busy=%b want 0", busy);
      end
      exp_p = '0;
   endtask

   task automatic test_basic();
      do_op(4'b1011, 4'b0111, 1'b0, "basic");
      checks++;
      if (exp_p !== 8'b0011_0001 || p !== 8'b0011_0001) begin
         errors++;
         $display("FAIL basic literal: p=%h want 31", p);
      end
   endtask

   task automatic test_square_zero();
      do_op(4'b1111, 4'b1111, 1'b0, "square");
      checks++;
      if (p !== 8'b0101_0101) begin
         errors++;
         $display("FAIL square literal: p=%h want 55", p);
      end
      do_op(4'b0000, 4'b1010, 1'b0, "zero_a");
      do_op(4'b0110, 4'b0000, 1'b0, "zero_b");
   endtask

   task automatic test_start_ignored();
      do_op(4'b1001, 4'b0011, 1'b1, "start_ignored");
      checks++;
      if (p !== 8'b0001_1011) begin
         errors++;
         $display("FAIL start_ignored literal: p=%h want 1b", p);
      end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      a = 4'b1011; b = 4'b0111; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || p !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid: busy=%b done=%b p=%h, want 0 0 00", busy, done, p);
      end
      rst_n = 1'b1;
      exp_p = '0;
      for (int k = 0; k < 2 * W; k++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || busy !== 1'b0 || p !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid aftermath: pulses=%0d busy=%b p=%h, want 0 0 00",
                  pulses, busy, p);
      end
      do_op(4'b1011, 4'b0111, 1'b0, "after_reset");
   endtask

   task automatic test_skip();
      do_op(4'b1001, 4'b0001, 1'b0, "skip_b1");
      do_op(4'b1001, 4'b0100, 1'b0, "skip_b4");
      do_op(4'b0111, 4'b1000, 1'b0, "skip_b8");
   endtask

   task automatic test_back_to_back();
      int got;
      a = 4'b1001; b = 4'b0011; start = 1'b1;
      tick();
      got = -1;
      for (int k = 1; k <= 3 * W; k++) begin
         tick();
         if (done === 1'b1) begin
            got = k;
            break;
         end
      end
      exp_p = clmul(4'b1001, 4'b0011);
      checks++;
      if (got != run_steps(4'b0011) || p !== exp_p) begin
         errors++;
         $display("FAIL b2b first: edge=%0d p=%h, want %0d %h", got, p, run_steps(4'b0011), exp_p);
      end
      a = 4'b0110; b = 4'b0101;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b idle gap: busy=%b done=%b, want 0 0", busy, done);
      end
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b accept: busy=%b want 1", busy);
      end
      got = -1;
      for (int k = 1; k <= 3 * W; k++) begin
         tick();
         if (done === 1'b1) begin
            got = k;
            break;
         end
      end
      exp_p = clmul(4'b0110, 4'b0101);
      checks++;
      if (got != run_steps(4'b0101) || p !== exp_p) begin
         errors++;
         $display("FAIL b2b second: edge=%0d p=%h, want %0d %h", got, p, run_steps(4'b0101), exp_p);
      end
      tick();
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++)
         do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "random");
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      test_reset();
      test_basic();
      test_square_zero();
      test_start_ignored();
      test_reset_mid();
      test_skip();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
